// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and nine's-complement helper for the
// digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_ADJ     = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry and invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        if (s > {1'b0, BCD_MAX}) begin
            sum  = s[3:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            sum  = s[3:0];
            cout = 1'b0;
        end
        invalid = (a > BCD_MAX) | (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder, LS digit first, with start/ready and valid/ready
// handshakes. Define BCD_SUB_EN to enable the A-B (nine's complement) path.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic                       in_ready,
    input  logic [4*NDIGITS-1:0]       A,
    input  logic [4*NDIGITS-1:0]       B,
    input  logic                       carry_in,
    input  logic                       op_sub,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [4*NDIGITS+3:0]       RSLT,
    output logic                       carry_out,
    output logic                       out_of_range
);

    localparam int                 W     = BCD_DIGIT_W * NDIGITS;
    localparam int                 IDX_W = $clog2(NDIGITS);
    localparam logic [IDX_W-1:0]   LAST  = IDX_W'(NDIGITS - 1);

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic             op_q;
    logic             c_q;
    logic [IDX_W-1:0] idx;

    logic             op_accept;
    logic [3:0]       b_dig;
    logic [3:0]       sum_dig;
    logic             cout_dig;
    logic             inv_dig;

`ifdef BCD_SUB_EN
    assign op_accept = op_sub;
    // Complementing preserves invalidity (10..15 map to 15..10), so the adder's flag still covers B.
    assign b_dig     = op_q ? nines_comp(b_sh[3:0]) : b_sh[3:0];
`else
    logic op_sub_unused;
    assign op_sub_unused = op_sub;
    assign op_accept     = 1'b0;
    assign b_dig         = b_sh[3:0];
`endif

    bcd_digit_add u_digit (
        .a       (a_sh[3:0]),
        .b       (b_dig),
        .cin     (c_q),
        .sum     (sum_dig),
        .cout    (cout_dig),
        .invalid (inv_dig)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            result_valid <= 1'b0;
            RSLT         <= '0;
            carry_out    <= 1'b0;
            out_of_range <= 1'b0;
            a_sh         <= '0;
            b_sh         <= '0;
            op_q         <= 1'b0;
            c_q          <= 1'b0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh         <= A;
                        b_sh         <= B;
                        op_q         <= op_accept;
                        c_q          <= op_accept ? ~carry_in : carry_in;
                        idx          <= '0;
                        RSLT         <= '0;
                        carry_out    <= 1'b0;
                        out_of_range <= 1'b0;
                        in_ready     <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sh                                  <= a_sh >> BCD_DIGIT_W;
                    b_sh                                  <= b_sh >> BCD_DIGIT_W;
                    c_q                                   <= cout_dig;
                    RSLT[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= sum_dig;
                    out_of_range                          <= out_of_range | inv_dig;
                    idx                                   <= idx + 1'b1;
                    if (idx == LAST) begin
                        RSLT[W +: BCD_DIGIT_W] <= op_q ? 4'h0 : {3'b0, cout_dig};
                        carry_out              <= op_q ? ~cout_dig : cout_dig;
                        result_valid           <= 1'b1;
                        state                  <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed, table-driven bench for bcd_addsub_serial with NDIGITS=4; sub vectors
// are included only when BCD_SUB_EN is defined.
module tb_bcd_addsub_serial;

    localparam int ND = 4;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            in_ready;
    logic [4*ND-1:0] A;
    logic [4*ND-1:0] B;
    logic            carry_in;
    logic            op_sub;
    logic            result_valid;
    logic            result_ready;
    logic [4*ND+3:0] RSLT;
    logic            carry_out;
    logic            out_of_range;

    int checks;
    int errors;

    bcd_addsub_serial #(.NDIGITS(ND)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .carry_in     (carry_in),
        .op_sub       (op_sub),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .RSLT         (RSLT),
        .carry_out    (carry_out),
        .out_of_range (out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [19:0] rslt;
        logic        co;
        logic        oor;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait (bounded) for result_valid; returns cycles after accept.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic op, output int cycles);
        A        = a;
        B        = b;
        carry_in = cin;
        op_sub   = op;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        A      = '0;
        B      = '0;
        cycles = 0;
        while (!result_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("valid_drop", {31'b0, result_valid}, 32'd0);
        check("in_ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        launch(v.a, v.b, v.cin, v.op, cyc);
        check({tag, "_latency"}, cyc, ND);
        check({tag, "_rslt"}, {12'b0, RSLT}, {12'b0, v.rslt});
        check({tag, "_co"}, {31'b0, carry_out}, {31'b0, v.co});
        check({tag, "_oor"}, {31'b0, out_of_range}, {31'b0, v.oor});
        consume();
    endtask

    initial begin
        int        cyc;
        logic [19:0] held;
        logic        stable;

        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        A            = '0;
        B            = '0;
        carry_in     = 1'b0;
        op_sub       = 1'b0;
        result_ready = 1'b0;

        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 1'b0, 20'h06912, 1'b0, 1'b0});
        vecs.push_back('{16'h9999, 16'h0001, 1'b0, 1'b0, 20'h10000, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 20'h00001, 1'b0, 1'b0});
        vecs.push_back('{16'h12A4, 16'h0000, 1'b0, 1'b0, 20'h01304, 1'b0, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{16'h4321, 16'h8765, 1'b0, 1'b0, 20'h13086, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0B00, 1'b0, 1'b0, 20'h01100, 1'b0, 1'b1});
`ifdef BCD_SUB_EN
        vecs.push_back('{16'h5000, 16'h1234, 1'b0, 1'b1, 20'h03766, 1'b0, 1'b0});
        vecs.push_back('{16'h1234, 16'h5000, 1'b0, 1'b1, 20'h06234, 1'b1, 1'b0});
        vecs.push_back('{16'h5000, 16'h1234, 1'b1, 1'b1, 20'h03765, 1'b0, 1'b0});
        vecs.push_back('{16'h0007, 16'h0007, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b0});
`else
        vecs.push_back('{16'h1234, 16'h5678, 1'b0, 1'b1, 20'h06912, 1'b0, 1'b0});
`endif

        repeat (3) tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, result_valid}, 32'd0);
        check("rst_rslt", {12'b0, RSLT}, 32'd0);
        check("rst_co", {31'b0, carry_out}, 32'd0);
        check("rst_oor", {31'b0, out_of_range}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold and extra starts be ignored.
        launch(16'h1234, 16'h5678, 1'b0, 1'b0, cyc);
        check("hold_latency", cyc, ND);
        held   = RSLT;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            A        = 16'h9999;
            B        = 16'h9999;
            carry_in = 1'b1;
            start    = i[0];
            tick();
            if (RSLT !== held || in_ready !== 1'b0 || result_valid !== 1'b1 || carry_out !== 1'b0)
                stable = 1'b0;
        end
        start = 1'b0;
        check("hold_stable", {31'b0, stable}, 32'd1);
        check("hold_rslt", {12'b0, RSLT}, 32'h06912);
        consume();
        tick();
        check("no_queued_op", {31'b0, result_valid}, 32'd0);
        check("no_queued_ready", {31'b0, in_ready}, 32'd1);

        // Reset mid-operation at idx=2.
        A        = 16'h9999;
        B        = 16'h0001;
        carry_in = 1'b0;
        op_sub   = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_valid", {31'b0, result_valid}, 32'd0);
        check("abort_rslt", {12'b0, RSLT}, 32'd0);
        repeat (6) tick();
        check("abort_no_result", {31'b0, result_valid}, 32'd0);
        run_vec(vecs[0], "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
